countdown_timer: RTL and testbench
==================================

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 Parameter DIGITS, default 2, number of BCD digits counted and displayed (1..8).
REQ-002 Parameter TICK_DIV, default 50000000, clk cycles per count tick (>=2).
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset; sampled only on rising edge of clk.
REQ-005 load  input  1  level; when high, load_val is captured this cycle.
REQ-006 load_val  input  4*DIGITS  BCD start value, digit 0 in bits [3:0].
REQ-007 start  input  1  level; request to begin or resume counting.
REQ-008 pause  input  1  level; request to suspend counting.
REQ-009 bcd_out  output  4*DIGITS  current count, BCD, registered.
REQ-010 ssd_out  output  7*DIGITS  segments per digit, active-low, bit 0 = a ... bit 6 = g, digit 0 in bits [6:0].
REQ-011 running  output  1  high while state is RUN.
REQ-012 done  output  1  high while state is DONE.

Function
REQ-013 States SHALL be IDLE, RUN, PAUSE, DONE, encoded per the shared package.
REQ-014 Command priority within one cycle SHALL be load > start > pause.
REQ-015 load in any state: count <= load_val (any digit >9 saturated to 9), prescaler <= TICK_DIV-1, state <= IDLE.
REQ-016 start in IDLE or PAUSE with count != 0: state <= RUN next cycle; start with count == 0: state <= DONE.
REQ-017 start in RUN or DONE SHALL have no effect.
REQ-018 pause in RUN: state <= PAUSE; prescaler holds its value; pause in any other state has no effect.
REQ-019 In RUN, the prescaler SHALL decrement each cycle; at 0 it reloads TICK_DIV-1 and asserts an internal tick for that cycle.
REQ-020 On tick, count SHALL decrement by one in BCD: digit 0 -> 9 with borrow into the next digit; bcd_out updates one cycle after the tick cycle.
REQ-021 The tick that takes count to 0 SHALL also move state to DONE in the same edge; count never wraps below 0.
REQ-022 In DONE, count holds at 0 and the prescaler keeps running (blink timebase only); only load or reset exits DONE.
REQ-023 In IDLE and PAUSE, count SHALL not change.
REQ-024 ssd_out SHALL be a combinational decode of bcd_out: 0-9 standard digits; no other codes are reachable.
REQ-025 running and done SHALL be registered state decodes, never both high.

Reset
REQ-026 On reset low at a clk edge: state IDLE, count all zeros, prescaler TICK_DIV-1, blink phase 0.
REQ-027 Reset values: bcd_out = 0, ssd_out = the "0" pattern on every digit (7'b1000000), running = 0, done = 0.
REQ-028 Reset low SHALL override load/start/pause in the same cycle, including mid-RUN.

Configuration
REQ-029 Macro COUNTDOWN_TIMER_DONE_BLINK_EN defined: in DONE, a blink phase bit toggles on each tick; when it is 1, ssd_out is all ones (blank); leaving DONE clears the phase.
REQ-030 Macro absent: ssd_out always shows bcd_out; no blink register exists.

Structure
REQ-031 Package countdown_timer_pkg SHALL hold the state typedef, segment blank constant 7'h7F, and the digit-to-segment table for 0-9.
REQ-032 Sub-module bcd_digit_down SHALL implement one digit: inputs dec, load, load digit; outputs digit, borrow (dec && digit==0); countdown_timer instantiates DIGITS of them in a chain.
REQ-033 Digit decode SHALL be a function in the package, not a further sub-module.

Verification (DIGITS=2, TICK_DIV=4)
REQ-034 load_val=8'h12, start -> bcd_out goes 12,11,10,09,...,00, one step per 4 clocks; done rises with 00; running falls same edge.
REQ-035 load 8'h05, start, pause after 2 ticks -> bcd_out holds 03 for 20 cycles; start -> 02 follows exactly 4 - (cycles elapsed before pause) clocks later.
REQ-036 load_val=8'h3F -> bcd_out = 39; load_val=8'h00 then start -> done next cycle, running never high.
REQ-037 load and start asserted together while RUN -> state IDLE, bcd_out = load_val, no decrement.
REQ-038 reset low mid-RUN at count 07 -> next edge bcd_out 00, ssd_out 14'h2040, running 0, done 0.
REQ-039 With COUNTDOWN_TIMER_DONE_BLINK_EN, in DONE -> ssd_out alternates 14'h3FFF / 14'h2040 every 4 clocks; without it -> steady 14'h2040.

Source files
------------

// File: rtl/countdown_timer_pkg.sv
// ---------------------------------------------------------------------------
// countdown_timer_pkg
// Shared types and helpers for the BCD countdown timer.
//   state_e      : timer FSM states (IDLE, RUN, PAUSE, DONE)
//   SEG_BLANK    : all segments off (active-low)
//   SEG_TABLE    : active-low 7-segment patterns for digits 0..9,
//                  bit 0 = segment a ... bit 6 = segment g
//   seg_decode   : digit -> segment pattern (codes above 9 show blank)
//   bcd_saturate : clamps a BCD digit to the range 0..9
// ---------------------------------------------------------------------------
package countdown_timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] SEG_TABLE [10] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  // Digits are always held in 0..9, so the blank fallback only guards
  // against an index outside the table.
  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    if (digit > 4'd9) begin
      return SEG_BLANK;
    end
    return SEG_TABLE[digit];
  endfunction

  function automatic logic [3:0] bcd_saturate(input logic [3:0] digit);
    return (digit > 4'd9) ? 4'd9 : digit;
  endfunction

endpackage

// File: rtl/countdown_timer_if.sv
// ---------------------------------------------------------------------------
// countdown_timer_if
// Command/status bundle of the countdown timer.
//   load      : capture load_val this cycle (level)
//   load_val  : BCD start value, digit 0 in bits [3:0]
//   start     : begin or resume counting (level)
//   pause     : suspend counting (level)
//   bcd_out   : current count, BCD, registered
//   ssd_out   : active-low segments, 7 bits per digit, digit 0 in [6:0]
//   running   : timer is counting
//   done      : timer has reached zero
// Modports: master drives commands, slave (the timer) drives status.
// ---------------------------------------------------------------------------
interface countdown_timer_if #(
  parameter int DIGITS = 2
);

  logic                  load;
  logic [4*DIGITS-1:0]   load_val;
  logic                  start;
  logic                  pause;
  logic [4*DIGITS-1:0]   bcd_out;
  logic [7*DIGITS-1:0]   ssd_out;
  logic                  running;
  logic                  done;

  modport master (
    output load, load_val, start, pause,
    input  bcd_out, ssd_out, running, done
  );

  modport slave (
    input  load, load_val, start, pause,
    output bcd_out, ssd_out, running, done
  );

endinterface

// File: rtl/countdown_timer_bcd_digit_down.sv
// ---------------------------------------------------------------------------
// bcd_digit_down
// One BCD digit of the countdown chain.
//   clk          : system clock
//   reset        : synchronous active-low reset (digit -> 0)
//   dec_i        : decrement this digit this cycle
//   load_i       : capture load_digit_i (wins over dec_i)
//   load_digit_i : digit value to load, saturated to 9
//   digit_o      : current digit value (registered)
//   borrow_o     : decrement while at 0, i.e. borrow into the next digit
// ---------------------------------------------------------------------------
module bcd_digit_down
  import countdown_timer_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       dec_i,
  input  logic       load_i,
  input  logic [3:0] load_digit_i,
  output logic [3:0] digit_o,
  output logic       borrow_o
);

  logic [3:0] digit_q, digit_d;

  // Next digit value: a load overrides a decrement, and a decrement
  // from 0 wraps to 9 while the borrow moves on to the next digit.
  always_comb begin
    digit_d = digit_q;
    if (load_i) begin
      digit_d = bcd_saturate(load_digit_i);
    end else if (dec_i) begin
      digit_d = (digit_q == 4'd0) ? 4'd9 : digit_q - 4'd1;
    end
  end

  // Digit register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      digit_q <= 4'd0;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit_o  = digit_q;
  assign borrow_o = dec_i && (digit_q == 4'd0);

endmodule

// File: rtl/countdown_timer.sv
// ---------------------------------------------------------------------------
// countdown_timer
// BCD countdown timer with a prescaled tick and 7-segment outputs.
//   DIGITS   : number of BCD digits (1..8)
//   TICK_DIV : clk cycles per count tick (>= 2)
//   clk      : system clock, all state changes on the rising edge
//   reset    : synchronous active-low reset
//   bus      : countdown_timer_if.slave (commands in, count/segments out)
// Optional build macro COUNTDOWN_TIMER_DONE_BLINK_EN: while in DONE the
// displays blank on alternate tick periods.
// ---------------------------------------------------------------------------
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int DIGITS   = 2,
  parameter int TICK_DIV = 50000000
) (
  input  logic              clk,
  input  logic              reset,
  countdown_timer_if.slave  bus
);

  localparam int CW = 4 * DIGITS;
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  state_e          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [CW-1:0]   count;
  logic [DIGITS:0] decChain;
  logic [7*DIGITS-1:0] ssd;
  logic            runAdvance;
  logic            doneAdvance;
  logic            tick;
  logic            lastTick;
  logic            blank;

  // The prescaler advances in RUN unless this cycle suspends or reloads
  // the timer, and free-runs in DONE as the blink timebase.
  always_comb begin
    runAdvance  = (state_q == RUN) && !bus.load && !bus.pause;
    doneAdvance = (state_q == DONE) && !bus.load;
    tick        = (runAdvance || doneAdvance) && (presc_q == '0);
    decChain[0] = tick && (state_q == RUN) && (count != '0);
    // A borrow out of the top digit would be an underflow; treat it as the
    // end of the run as well so the count can never wrap.
    lastTick    = decChain[0] && ((count == CW'(1)) || decChain[DIGITS]);
  end

  // Prescaler next value: reload on load or on reaching 0, hold otherwise.
  always_comb begin
    presc_d = presc_q;
    if (bus.load) begin
      presc_d = PRESC_MAX;
    end else if (runAdvance || doneAdvance) begin
      presc_d = (presc_q == '0) ? PRESC_MAX : presc_q - 1'b1;
    end
  end

  // Count digits chained least significant first, borrow feeding upward.
  for (genvar g = 0; g < DIGITS; g++) begin : gDigit
    bcd_digit_down uDigit (
      .clk          (clk),
      .reset        (reset),
      .dec_i        (decChain[g]),
      .load_i       (bus.load),
      .load_digit_i (bus.load_val[4*g +: 4]),
      .digit_o      (count[4*g +: 4]),
      .borrow_o     (decChain[g+1])
    );
  end

  // FSM state and prescaler registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      presc_q <= PRESC_MAX;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
    end
  end

  // Next-state logic: load beats start, start beats pause; start is only
  // heard in IDLE/PAUSE and pause only in RUN.
  always_comb begin
    state_d = state_q;
    if (bus.load) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, PAUSE: begin
          if (bus.start) begin
            state_d = (count != '0) ? RUN : DONE;
          end
        end
        RUN: begin
          if (bus.pause) begin
            state_d = PAUSE;
          end else if (lastTick) begin
            state_d = DONE;
          end
        end
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Status outputs decoded from the registered state.
  always_comb begin
    bus.running = (state_q == RUN);
    bus.done    = (state_q == DONE);
    bus.bcd_out = count;
  end

`ifdef COUNTDOWN_TIMER_DONE_BLINK_EN
  logic blink_q, blink_d;

  // Blink phase toggles on every tick while staying in DONE and is
  // cleared on any exit from DONE.
  always_comb begin
    blink_d = 1'b0;
    if ((state_q == DONE) && (state_d == DONE)) begin
      blink_d = blink_q ^ tick;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      blink_q <= 1'b0;
    end else begin
      blink_q <= blink_d;
    end
  end

  assign blank = blink_q;
`else
  assign blank = 1'b0;
`endif

  // Segment decode of the registered count, blanked during blink phase.
  always_comb begin
    ssd = '0;
    for (int i = 0; i < DIGITS; i++) begin
      ssd[7*i +: 7] = blank ? SEG_BLANK : seg_decode(count[4*i +: 4]);
    end
    bus.ssd_out = ssd;
  end

endmodule

// File: tb/tb_countdown_timer.sv
// ---------------------------------------------------------------------------
// tb_countdown_timer
// Directed self-checking bench for countdown_timer (DIGITS=2, TICK_DIV=4).
// Expected blink behaviour follows COUNTDOWN_TIMER_DONE_BLINK_EN.
// ---------------------------------------------------------------------------
module tb_countdown_timer;

  localparam int DIGITS   = 2;
  localparam int TICK_DIV = 4;

  logic clk = 1'b0;
  logic reset;
  logic blinkExp;
  int   checks = 0;
  int   errors = 0;

  countdown_timer_if #(.DIGITS(DIGITS)) bus ();

  countdown_timer #(
    .DIGITS   (DIGITS),
    .TICK_DIV (TICK_DIV)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  // Active-low segment patterns for one digit, written out by hand.
  function automatic logic [6:0] segOf(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  // Decimal value to two-digit BCD.
  function automatic logic [7:0] bcdOf(input int v);
    return 8'(((v / 10) * 16) + (v % 10));
  endfunction

  // Advance n rising edges, landing 1 ns after the last one.
  task automatic stepClk(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic ld, input logic [7:0] val,
                               input logic st, input logic ps);
    bus.load     = ld;
    bus.load_val = val;
    bus.start    = st;
    bus.pause    = ps;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] expBcd,
                             input logic expBlank, input logic expRun,
                             input logic expDone);
    logic [13:0] expSsd;
    expSsd = expBlank ? 14'h3FFF : {segOf(expBcd[7:4]), segOf(expBcd[3:0])};
    checks++;
    assert (bus.bcd_out === expBcd) else begin
      errors++;
      $error("[TB] FAIL %s bcd_out got %h expected %h", tag, bus.bcd_out, expBcd);
    end
    checks++;
    assert (bus.ssd_out === expSsd) else begin
      errors++;
      $error("[TB] FAIL %s ssd_out got %h expected %h", tag, bus.ssd_out, expSsd);
    end
    checks++;
    assert (bus.running === expRun) else begin
      errors++;
      $error("[TB] FAIL %s running got %b expected %b", tag, bus.running, expRun);
    end
    checks++;
    assert (bus.done === expDone) else begin
      errors++;
      $error("[TB] FAIL %s done got %b expected %b", tag, bus.done, expDone);
    end
  endtask

  // Directed sequence of steps, each followed by its expected outputs.
  initial begin
    // Reset with commands asserted: reset must win.
    reset = 1'b0;
    applyStimulus(1'b1, 8'h12, 1'b1, 1'b0);
    stepClk(2);
    checkOutput("reset", 8'h00, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;

    // Load 12 and stay idle.
    applyStimulus(1'b1, 8'h12, 1'b0, 1'b0);
    stepClk(1);
    checkOutput("load12", 8'h12, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    stepClk(3);
    checkOutput("idleHold", 8'h12, 1'b0, 1'b0, 1'b0);

    // Count 12 down to 00, one step every 4 clocks.
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    stepClk(1);
    checkOutput("startRun", 8'h12, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    for (int n = 1; n <= 12; n++) begin
      stepClk(3);
      checkOutput("holdStep", bcdOf(13 - n), 1'b0, 1'b1, 1'b0);
      stepClk(1);
      checkOutput("tickStep", bcdOf(12 - n), 1'b0, (n != 12), (n == 12));
    end

    // DONE: start ignored, display steady or blinking per build.
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    for (int d = 1; d <= 8; d++) begin
      stepClk(1);
`ifdef COUNTDOWN_TIMER_DONE_BLINK_EN
      blinkExp = (((d / 4) % 2) == 1);
`else
      blinkExp = 1'b0;
`endif
      checkOutput("doneDisplay", 8'h00, blinkExp, 1'b0, 1'b1);
    end

    // Saturating load, then zero load followed by start.
    applyStimulus(1'b1, 8'h3F, 1'b0, 1'b0);
    stepClk(1);
    checkOutput("satLoad", 8'h39, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h00, 1'b0, 1'b0);
    stepClk(1);
    checkOutput("loadZero", 8'h00, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    stepClk(1);
    checkOutput("startZero", 8'h00, 1'b0, 1'b0, 1'b1);

    // Load 05, run two ticks, pause one clock into the third period.
    applyStimulus(1'b1, 8'h05, 1'b0, 1'b0);
    stepClk(1);
    checkOutput("load05", 8'h05, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    stepClk(1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    stepClk(8);
    checkOutput("twoTicks", 8'h03, 1'b0, 1'b1, 1'b0);
    stepClk(1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    stepClk(1);
    checkOutput("pauseEnter", 8'h03, 1'b0, 1'b0, 1'b0);
    stepClk(19);
    checkOutput("pauseHold", 8'h03, 1'b0, 1'b0, 1'b0);

    // Resume: remaining 3 clocks of the interrupted period.
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    stepClk(1);
    checkOutput("resume", 8'h03, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    stepClk(2);
    checkOutput("resumeWait", 8'h03, 1'b0, 1'b1, 1'b0);
    stepClk(1);
    checkOutput("resumeTick", 8'h02, 1'b0, 1'b1, 1'b0);

    // Load together with start while running.
    applyStimulus(1'b1, 8'h47, 1'b1, 1'b0);
    stepClk(1);
    checkOutput("loadInRun", 8'h47, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    stepClk(5);
    checkOutput("loadNoDec", 8'h47, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of a run at 07.
    applyStimulus(1'b1, 8'h09, 1'b0, 1'b0);
    stepClk(1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    stepClk(1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    stepClk(8);
    checkOutput("runAt07", 8'h07, 1'b0, 1'b1, 1'b0);
    stepClk(1);
    reset = 1'b0;
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
    stepClk(1);
    checkOutput("resetMidRun", 8'h00, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;

    // Pause ignored in IDLE; start beats pause; pause then acts in RUN.
    applyStimulus(1'b1, 8'h08, 1'b0, 1'b0);
    stepClk(1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    stepClk(2);
    checkOutput("pauseIdle", 8'h08, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
    stepClk(1);
    checkOutput("startOverPause", 8'h08, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    stepClk(1);
    checkOutput("pauseRun", 8'h08, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
